// File: rtl/group0_conv1d_acc_pkg.sv
// Shared constants and types for the group0 1-D convolution accumulator.
// Signed limits are computed for any width up to C_MAX_W bits.
package group0_conv1d_acc_pkg;

  localparam int unsigned C_DATA_W = 64;
  localparam int unsigned C_CNT_W  = 16;
  localparam int unsigned C_MAX_W  = 128;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  function automatic logic [C_MAX_W-1:0] smax(input int unsigned w);
    return (C_MAX_W'(1) << (w - 1)) - C_MAX_W'(1);
  endfunction

  // Only bit w-1 set: the most negative value once truncated to w bits.
  function automatic logic [C_MAX_W-1:0] smin(input int unsigned w);
    return C_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/group0_conv1d_acc_if.sv
// Issue, multiplier and result handshake bundle for group0_conv1d_acc.
interface group0_conv1d_acc_if
  import group0_conv1d_acc_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned CNT_W  = C_CNT_W
) ();

  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              mul_ce;
  logic [DATA_W-1:0] mul_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_last, mul_dout, out_ready,
    output in_ready, mul_ce, out_valid, out_data, out_count, out_ovf
  );

  modport master (
    output in_valid, in_last, mul_dout, out_ready,
    input  in_ready, mul_ce, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/group0_tag_delay.sv
// Enable-gated shift line carrying {valid,last} tags alongside the multiplier pipe.
module group0_tag_delay
  import group0_conv1d_acc_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t line_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (en_i) begin
      line_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign tag_o = line_q[DEPTH-1];

endmodule

// File: rtl/group0_conv1d_acc.sv
// Dot-product accumulator behind a pipelined signed multiplier; emits one
// result per in_last with term count and sticky overflow, wrap or saturate.
module group0_conv1d_acc
  import group0_conv1d_acc_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned DATA_W      = C_DATA_W,
  parameter int unsigned CNT_W       = C_CNT_W,
  parameter int unsigned SATURATE    = 0
) (
  input logic               clk,
  input logic               reset,
  group0_conv1d_acc_if.slave acc_if
);

  localparam logic [DATA_W-1:0] SMAX = DATA_W'(smax(DATA_W));
  localparam logic [DATA_W-1:0] SMIN = DATA_W'(smin(DATA_W));

  tag_t              tag_in;
  tag_t              tag_al;
  logic              ce;
  logic              take;
  logic [DATA_W:0]   base;
  logic [DATA_W:0]   sum;
  logic              ovf_now;
  logic [DATA_W-1:0] res;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              first_q, first_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d;

  assign ce              = ~(out_valid_q & ~acc_if.out_ready);
  assign acc_if.mul_ce   = ce;
  assign acc_if.in_ready = ce;

  always_comb begin
    tag_in.valid = acc_if.in_valid;
    tag_in.last  = acc_if.in_valid & acc_if.in_last;
  end

  group0_tag_delay #(
    .DEPTH (MUL_LATENCY)
  ) u_tag_delay (
    .clk   (clk),
    .reset (reset),
    .en_i  (ce),
    .tag_i (tag_in),
    .tag_o (tag_al)
  );

  assign take = ce & tag_al.valid;

  // One guard bit: overflow shows as the top two sum bits disagreeing.
  always_comb begin
    base    = first_q ? '0 : {acc_q[DATA_W-1], acc_q};
    sum     = base + {acc_if.mul_dout[DATA_W-1], acc_if.mul_dout};
    ovf_now = sum[DATA_W] ^ sum[DATA_W-1];
    if ((SATURATE != 0) && ovf_now) res = sum[DATA_W] ? SMIN : SMAX;
    else                            res = sum[DATA_W-1:0];
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (out_valid_q && acc_if.out_ready) out_valid_d = 1'b0;
    // A last term landing on the consume cycle overrides the clear above.
    if (take) begin
      if (tag_al.last) begin
        out_data_d  = res;
        out_count_d = cnt_q + CNT_W'(1);
        out_ovf_d   = ovf_q | ovf_now;
        out_valid_d = 1'b1;
        first_d     = 1'b1;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d   = res;
        cnt_d   = cnt_q + CNT_W'(1);
        ovf_d   = ovf_q | ovf_now;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign acc_if.out_valid = out_valid_q;
  assign acc_if.out_data  = out_data_q;
  assign acc_if.out_count = out_count_q;
  assign acc_if.out_ovf   = out_ovf_q;

endmodule

// File: doc/group0_conv1d_acc.md
GROUP0_CONV1D_ACC -- requirements
Module: group0_conv1d_acc

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 1: register stages in the upstream signed multiplier (1..4).
REQ-002 SHALL have parameter DATA_W, default 64: product and accumulator width.
REQ-003 SHALL have parameter CNT_W, default 16: width of the term counter.
REQ-004 SHALL have parameter SATURATE, default 0: 0 = two's-complement wrap, 1 = saturate to signed DATA_W limits.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates occur on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  in  1  a multiplier operand pair is presented this cycle.
REQ-008 SHALL have port in_last  in  1  final term of the current dot product; qualified by in_valid.
REQ-009 SHALL have port in_ready  out  1  issue accepted; always equal to mul_ce.
REQ-010 SHALL have port mul_ce  out  1  clock enable driven to the multiplier.
REQ-011 SHALL have port mul_dout  in  DATA_W  signed product from the multiplier.
REQ-012 SHALL have port out_valid  out  1  result held on out_data.
REQ-013 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-014 SHALL have port out_data  out  DATA_W  signed dot-product sum.
REQ-015 SHALL have port out_count  out  CNT_W  number of terms summed, modulo 2^CNT_W.
REQ-016 SHALL have port out_ovf  out  1  overflow (wrap or clamp) occurred during this result.

Function
REQ-017 SHALL drive mul_ce = NOT(out_valid AND NOT out_ready), a purely combinational stall.
REQ-018 SHALL track {valid,last} tags in a MUL_LATENCY-deep shift line that advances only when mul_ce=1; the tag leaving the line aligns with mul_dout.
REQ-019 SHALL, when mul_ce=1 and the aligned tag is valid, compute sum = (first ? 0 : acc) + mul_dout at DATA_W+1 bits.
REQ-020 SHALL, when SATURATE=0, keep the low DATA_W bits; when SATURATE=1, clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1); either case sets the sticky ovf bit when the sum exceeds the signed range.
REQ-021 SHALL, on a non-last aligned term, store acc, increment cnt with wrap, and clear first.
REQ-022 SHALL, on a last aligned term, load out_data=sum, out_count=cnt+1, out_ovf=(ovf OR this term's overflow), set out_valid, and set first, cnt=0, ovf=0.
REQ-023 SHALL clear out_valid on out_valid AND out_ready unless a new last term loads in the same cycle, in which case the new result replaces the old with out_valid kept at 1.
REQ-024 SHALL hold out_data, out_count and out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL accept a single-term dot product (in_valid with in_last) and produce out_count=1.
REQ-026 SHALL have a latency of MUL_LATENCY+1 cycles from accepted last issue to out_valid, with no stall.
REQ-027 SHALL ignore in_last when in_valid=0.

Reset
REQ-028 SHALL, on assertion of reset, clear asynchronously: tag line, acc, cnt, ovf, out_valid, out_data, out_count, out_ovf, and set first=1.
REQ-029 SHALL discard any partially accumulated dot product when reset is asserted mid-operation; no result is emitted for it.

Structure
REQ-030 SHALL take DATA_W, CNT_W and the signed max/min constants from the shared group0 conv1d package.
REQ-031 SHALL implement the tag shift line as one sub-module, group0_tag_delay, parameterised by depth and enable.

Verification
REQ-032 SHALL verify products 3, -5, 10 (last), no stall -> out_data=8, out_count=3, out_ovf=0, out_valid after MUL_LATENCY+1 cycles.
REQ-033 SHALL verify SATURATE=0 with 0x7FFF_FFFF_FFFF_FFFF + 1 (last) -> out_data=0x8000_0000_0000_0000, out_ovf=1; SATURATE=1 -> 0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
REQ-034 SHALL verify out_ready=0 for 5 cycles with a result pending -> mul_ce=in_ready=0, outputs stable, the in-flight term is not lost, and the next sum is correct after release.
REQ-035 SHALL verify back-to-back single-term products 7 then -2 with out_ready=1 -> two results, 7 then -2, each out_count=1, in consecutive cycles.
REQ-036 SHALL verify reset asserted after 2 of 4 terms, then a new sequence 1, 1 (last) -> only result out_data=2, out_count=2.
